bli201_dtim_arb: RTL and testbench
==================================

Name: bli201_dtim_arb

Overview:
- Two-port arbiter/sequencer in front of the single-port DTIM BRAM (1024 x 32, byte write mask, synchronous read).
- Port 0 is the core load/store unit; port 1 is the debug/program-loader master.
- Grants at most one access per cycle with round-robin priority, drives the RAM enable/address/mask/data, and routes read data back to the issuing port at fixed latency.
- Flags out-of-range addresses with an error response without touching the RAM.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte base address of the DTIM window
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of 2)
- ADDR_W, 10, RAM word-address width, = log2(DEPTH_WORDS)
- RD_LAT, 1, RAM read latency in cycles (1 = no output register, 2 = output register); legal values 1 or 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid  in  1  port 0 request valid
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_req_addr  in  32  byte address; bits [1:0] ignored
- p0_req_wmask  in  4  byte write enables; 4'b0000 = read
- p0_req_wdata  in  32  write data
- p0_rsp_valid  out  1  response valid, one cycle pulse
- p0_rsp_rdata  out  32  read data (0 on writes and errors)
- p0_rsp_err  out  1  address outside window
- p1_req_valid, p1_req_ready, p1_req_addr, p1_req_wmask, p1_req_wdata, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err: same as port 0, for port 1
- ram_en  out  1  RAM enable, asserted for both reads and writes
- ram_addr  out  ADDR_W  RAM word address
- ram_wmask  out  4  RAM byte write enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid RD_LAT cycles after ram_en

Behaviour:
- Reset (async assert, sync deassert by the system): rr_ptr=0; response pipeline cleared; all rsp_valid/rsp_err=0; rsp_rdata=0. Combinational outputs are forced low while rst_n=0: ready, ram_en, ram_wmask.
- Clock and reset interface: one clock domain, clk; reset is rst_n, asynchronous, active-low.
- Arbitration (combinational, same cycle):
  - Only one port valid: that port is granted.
  - Both valid: the port selected by rr_ptr is granted.
  - On any grant, rr_ptr <= index of the non-granted port.
  - pX_req_ready = grantX. Requests are never otherwise back-pressured, because responses cannot stall.
- Range check: in_range = (addr - BASE_ADDR) < 4*DEPTH_WORDS, evaluated in unsigned 32-bit arithmetic (wraps, so addresses below the base fail).
  - Granted and in range: ram_en=1, ram_addr=(addr-BASE_ADDR)[ADDR_W+1:2], ram_wmask/ram_wdata from the request.
  - Granted and out of range: ram_en=0, ram_wmask=0.
  - No grant: ram_en=0, ram_wmask=0, ram_addr/ram_wdata hold the last values (no toggling).
- Response pipeline: shift register of depth RD_LAT carrying {valid, port, is_read, err}.
  - Exactly RD_LAT cycles after a grant, the issuing port sees rsp_valid=1 for one cycle.
  - rsp_rdata = ram_rdata when is_read && !err, else 0. rsp_err = err.
  - Responses are returned in order, and each port has at most one response per cycle.
- Back-to-back: a new grant is allowed every cycle, including consecutive grants to the same port when the other is idle.
- Read-after-write to the same word in consecutive cycles returns the new data, because the RAM is WRITE_FIRST and the accesses are sequential.
- Simultaneous events:
  - Both ports writing the same word: the granted write happens first; the other is written the next cycle if still valid.
  - A port's request and its own response may coincide in the same cycle.
- Reset mid-operation: in-flight responses are discarded (no rsp_valid after reset release); rr_ptr returns to 0. A RAM write issued in the cycle reset asserts is not guaranteed.
- Requesters must hold addr/wmask/wdata stable while valid && !ready.

Decomposition:
- Shared package bli201_mem_pkg:
  - DTIM_BASE and DTIM_DEPTH constants
  - mem_req struct {addr, wmask, wdata}
  - mem_rsp struct {rdata, err}
  - resp_tag struct {valid, port, is_read, err}
- One sub-module: bli201_rsp_pipe, a parameterised RD_LAT-deep tag shift register with async active-low clear. The arbiter and address decode stay in the top module.

Test Plan:
- Port 0 writes 32'hDEADBEEF, wmask 4'hF, at 0x8000_0010; then reads the same address -> ram_addr=4 both cycles; read rsp_valid 1 cycle later (RD_LAT=1) with rdata 32'hDEADBEEF, err=0.
- Both ports hold valid reads for 4 cycles from reset -> grants alternate p0,p1,p0,p1; responses alternate with matching data.
- Byte write, wmask 4'b0100, wdata 32'h00AB0000, over word 32'h11223344 -> readback 32'h11AB3344.
- Port 1 reads 0x8000_1000 (one past the end) and 0x7FFF_FFFC -> ram_en=0; p1_rsp_err=1, rdata=0 after RD_LAT; port 0 traffic in the same cycles is unaffected.
- RD_LAT=2 build: 3 back-to-back reads -> 3 responses on cycles +2,+3,+4, in order, with correct data.
- Issue a read, then assert rst_n=0 the next cycle -> no rsp_valid ever appears; after release, the first contended grant goes to port 0.

Source files
------------

// File: rtl/bli201_mem_pkg.sv
// Shared types and constants for the DTIM arbiter slice.
//   DTIM_BASE / DTIM_DEPTH : default window base (bytes) and depth (words)
//   mem_req_t  : one request {addr, wmask, wdata}
//   mem_rsp_t  : one response {rdata, err}
//   resp_tag_t : per-access bookkeeping carried alongside the RAM read latency
package bli201_mem_pkg;

  localparam logic [31:0] DTIM_BASE  = 32'h8000_0000;
  localparam int          DTIM_DEPTH = 1024;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
    logic err;
  } resp_tag_t;

endpackage

// File: rtl/bli201_rsp_pipe.sv
// Response tag delay line: tag_in appears on tag_out exactly STAGES cycles
// later, lined up with the RAM read data.
//   clk, rst_n : clock, async active-low clear (drops in-flight tags)
//   tag_in     : tag of the access granted this cycle
//   tag_out    : tag of the access whose RAM data is valid this cycle
module bli201_rsp_pipe
  import bli201_mem_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  resp_tag_t tag_in,
  output resp_tag_t tag_out
);

  resp_tag_t [STAGES:1] tag_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= tag_in;
      for (int s = 2; s <= STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign tag_out = tag_pipe[STAGES];

endmodule

// File: rtl/bli201_dtim_arb.sv
// Two-port round-robin arbiter in front of the single-port DTIM BRAM.
//   p0_* : core load/store port      p1_* : debug/loader port
//   pX_req_* : valid/ready request, wmask==0 means read
//   pX_rsp_* : one-cycle response RD_LAT cycles after acceptance
//   ram_*    : BRAM enable/address/byte-mask/data, ram_rdata RD_LAT later
// Out-of-window requests are accepted but never reach the RAM; they
// return err=1 with rdata=0 at the normal latency.
module bli201_dtim_arb
  import bli201_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DTIM_BASE,
  parameter int          DEPTH_WORDS = DTIM_DEPTH,
  parameter int          ADDR_W      = 10,
  parameter int          RD_LAT      = 1          // 1 or 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [31:0]       p0_req_addr,
  input  logic [3:0]        p0_req_wmask,
  input  logic [31:0]       p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [31:0]       p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [31:0]       p1_req_addr,
  input  logic [3:0]        p1_req_wmask,
  input  logic [31:0]       p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [31:0]       p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wmask,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);

  mem_req_t          req0, req1, sel;
  logic              rr_ptr;
  logic              grant0, grant1, any_grant, in_range;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  resp_tag_t         tag_in, tag_out;
  mem_rsp_t          rsp;

  assign req0 = '{addr: p0_req_addr, wmask: p0_req_wmask, wdata: p0_req_wdata};
  assign req1 = '{addr: p1_req_addr, wmask: p1_req_wmask, wdata: p1_req_wdata};

  // rr_ptr names the port that wins a tie; gating with rst_n keeps every
  // request-side output quiet while reset is held.
  assign grant0    = rst_n && p0_req_valid && (!p1_req_valid || !rr_ptr);
  assign grant1    = rst_n && p1_req_valid && (!p0_req_valid ||  rr_ptr);
  assign any_grant = grant0 || grant1;
  assign sel       = grant1 ? req1 : req0;

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;

  // Unsigned wrap makes addresses below the base look huge, so one compare
  // covers both ends of the window.
  assign offset   = sel.addr - BASE_ADDR;
  assign in_range = offset < WIN_BYTES;

  assign ram_en    = any_grant && in_range;
  assign ram_wmask = ram_en ? sel.wmask : 4'h0;
  // Address/data hold their last granted value on idle cycles.
  assign ram_addr  = any_grant ? offset[ADDR_W+1:2] : addr_q;
  assign ram_wdata = any_grant ? sel.wdata : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (any_grant) begin
      rr_ptr  <= grant0;            // loser of this cycle gets next tie
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  assign tag_in = '{valid:   any_grant,
                    port:    grant1,
                    is_read: any_grant && (sel.wmask == 4'h0),
                    err:     any_grant && !in_range};

  bli201_rsp_pipe #(.STAGES(RD_LAT)) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rsp.rdata = (tag_out.is_read && !tag_out.err) ? ram_rdata : 32'h0;
  assign rsp.err   = tag_out.err;

  assign p0_rsp_valid = tag_out.valid && !tag_out.port;
  assign p1_rsp_valid = tag_out.valid &&  tag_out.port;
  assign p0_rsp_rdata = p0_rsp_valid ? rsp.rdata : 32'h0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp.rdata : 32'h0;
  assign p0_rsp_err   = p0_rsp_valid && rsp.err;
  assign p1_rsp_err   = p1_rsp_valid && rsp.err;

endmodule

// File: tb/tb_bli201_dtim_arb.sv
// Directed bench: instance a (RD_LAT=1, both ports) and instance b
// (RD_LAT=2, port 0 only), each with a WRITE_FIRST behavioural RAM.
module tb_bli201_dtim_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic [3:0]  p0_req_wmask;
  logic        p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic [3:0]  p1_req_wmask;
  logic        ram_en;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_wdata, ram_rdata;

  logic        b_p0_req_valid, b_p0_req_ready, b_p0_rsp_valid, b_p0_rsp_err;
  logic [31:0] b_p0_req_addr, b_p0_req_wdata, b_p0_rsp_rdata;
  logic [3:0]  b_p0_req_wmask;
  logic        b_p1_req_ready, b_p1_rsp_valid, b_p1_rsp_err;
  logic [31:0] b_p1_rsp_rdata;
  logic        b_ram_en;
  logic [9:0]  b_ram_addr;
  logic [3:0]  b_ram_wmask;
  logic [31:0] b_ram_wdata, b_ram_rdata, b_rd1;

  int n_vec = 0;
  int n_err = 0;

  bli201_dtim_arb #(.RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_wmask(p0_req_wmask),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_wmask(p1_req_wmask),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  bli201_dtim_arb #(.RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(b_p0_req_valid), .p0_req_ready(b_p0_req_ready),
    .p0_req_addr(b_p0_req_addr), .p0_req_wmask(b_p0_req_wmask),
    .p0_req_wdata(b_p0_req_wdata), .p0_rsp_valid(b_p0_rsp_valid),
    .p0_rsp_rdata(b_p0_rsp_rdata), .p0_rsp_err(b_p0_rsp_err),
    .p1_req_valid(1'b0), .p1_req_ready(b_p1_req_ready),
    .p1_req_addr(32'h0), .p1_req_wmask(4'h0),
    .p1_req_wdata(32'h0), .p1_rsp_valid(b_p1_rsp_valid),
    .p1_rsp_rdata(b_p1_rsp_rdata), .p1_rsp_err(b_p1_rsp_err),
    .ram_en(b_ram_en), .ram_addr(b_ram_addr), .ram_wmask(b_ram_wmask),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] d,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // WRITE_FIRST BRAM models
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      mem_a[ram_addr] <= merge(mem_a[ram_addr], ram_wdata, ram_wmask);
      ram_rdata       <= merge(mem_a[ram_addr], ram_wdata, ram_wmask);
    end
  end
  always @(posedge clk) begin
    if (b_ram_en) begin
      mem_b[b_ram_addr] <= merge(mem_b[b_ram_addr], b_ram_wdata, b_ram_wmask);
      b_rd1             <= merge(mem_b[b_ram_addr], b_ram_wdata, b_ram_wmask);
    end
    b_ram_rdata <= b_rd1;   // output register stage
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    p0_req_valid = v; p0_req_addr = a; p0_req_wmask = m; p0_req_wdata = d;
  endtask
  task automatic drv1(input logic v, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    p1_req_valid = v; p1_req_addr = a; p1_req_wmask = m; p1_req_wdata = d;
  endtask
  task automatic drvb(input logic v, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    b_p0_req_valid = v; b_p0_req_addr = a; b_p0_req_wmask = m; b_p0_req_wdata = d;
  endtask
  task automatic idle();
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0); drvb(0, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic g0;
    idle();
    // Reset: request held valid, outputs must stay quiet
    drv0(1, 32'h8000_0010, 4'hF, 32'h1234_5678);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'h0, p0_req_ready}, 0);
    chk("rst_ram_en", {31'h0, ram_en}, 0);
    chk("rst_wmask", {28'h0, ram_wmask}, 0);
    chk("rst_rsp", {28'h0, p0_rsp_valid, p0_rsp_err, p1_rsp_valid, p1_rsp_err}, 0);
    chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // Preload words via the DUTs
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drv0(1, 32'h8000_0020, 4'hF, 32'h0000_1111); else drv0(0, 0, 0, 0);
      if (i == 1) drv1(1, 32'h8000_0024, 4'hF, 32'h2222_0000); else drv1(0, 0, 0, 0);
      drvb(1, 32'h8000_0000 + 32'(4*(i+1)), 4'hF, 32'hB0B0_0000 + 32'(i+1));
      tick();
    end
    idle();
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Contended reads from reset: p0,p1,p0,p1
    drv0(1, 32'h8000_0020, 4'h0, 0);
    drv1(1, 32'h8000_0024, 4'h0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g0 = (i % 2 == 0);
      chk("rr_ready0", {31'h0, p0_req_ready}, {31'h0, g0});
      chk("rr_ready1", {31'h0, p1_req_ready}, {31'h0, !g0});
      chk("rr_addr", {22'h0, ram_addr}, g0 ? 32'd8 : 32'd9);
      if (i > 0) begin
        chk("rr_rsp0_v", {31'h0, p0_rsp_valid}, {31'h0, !g0});
        chk("rr_rsp1_v", {31'h0, p1_rsp_valid}, {31'h0, g0});
        chk("rr_rdata", g0 ? p1_rsp_rdata : p0_rsp_rdata, g0 ? 32'h2222_0000 : 32'h0000_1111);
      end
      tick();
    end
    idle();
    @(negedge clk);
    chk("rr_last_v", {30'h0, p1_rsp_valid, p0_rsp_valid}, 32'h2);
    chk("rr_last_d", p1_rsp_rdata, 32'h2222_0000);
    tick();

    // Write then read same word
    drv0(1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_ready", {31'h0, p0_req_ready}, 1);
    chk("wr_en", {31'h0, ram_en}, 1);
    chk("wr_addr", {22'h0, ram_addr}, 4);
    chk("wr_mask", {28'h0, ram_wmask}, 32'hF);
    chk("wr_data", ram_wdata, 32'hDEAD_BEEF);
    tick();
    drv0(1, 32'h8000_0010, 4'h0, 0);
    @(negedge clk);
    chk("rd_addr", {22'h0, ram_addr}, 4);
    chk("rd_mask", {28'h0, ram_wmask}, 0);
    chk("wr_rsp", {p0_rsp_rdata[30:0], p0_rsp_valid}, 1);
    tick();
    idle();
    @(negedge clk);
    chk("rd_rsp_v", {30'h0, p0_rsp_valid, p0_rsp_err}, 32'h2);
    chk("rd_rsp_d", p0_rsp_rdata, 32'hDEAD_BEEF);
    chk("idle_en", {31'h0, ram_en}, 0);
    chk("idle_addr_hold", {22'h0, ram_addr}, 4);
    tick();

    // Byte-lane write
    drv0(1, 32'h8000_0040, 4'hF, 32'h1122_3344);
    tick();
    drv0(1, 32'h8000_0040, 4'b0100, 32'h00AB_0000);
    @(negedge clk);
    chk("byte_mask", {28'h0, ram_wmask}, 32'h4);
    tick();
    drv0(1, 32'h8000_0040, 4'h0, 0);
    tick();
    idle();
    @(negedge clk);
    chk("byte_rd", p0_rsp_rdata, 32'h11AB_3344);
    tick();

    // Out-of-range on p1 interleaved with p0 (rr_ptr=1 now)
    drv0(1, 32'h8000_0010, 4'h0, 0);
    drv1(1, 32'h8000_1000, 4'h0, 0);
    @(negedge clk);
    chk("oor_grant", {30'h0, p1_req_ready, p0_req_ready}, 32'h2);
    chk("oor_en", {27'h0, ram_en, ram_wmask}, 0);
    tick();
    drv1(1, 32'h7FFF_FFFC, 4'h0, 0);
    @(negedge clk);
    chk("oor_p0_go", {22'h0, p0_req_ready, ram_en, ram_addr}, {22'h0, 2'b11, 10'd4});
    chk("oor_rsp1", {29'h0, p1_rsp_valid, p1_rsp_err, p0_rsp_valid}, 32'h6);
    chk("oor_rdata1", p1_rsp_rdata, 0);
    tick();
    drv0(0, 0, 0, 0);
    @(negedge clk);
    chk("low_grant", {30'h0, p1_req_ready, ram_en}, 32'h2);
    chk("oor_p0_rsp", {29'h0, p0_rsp_valid, p0_rsp_err, p1_rsp_valid}, 32'h4);
    chk("oor_p0_d", p0_rsp_rdata, 32'hDEAD_BEEF);
    tick();
    idle();
    @(negedge clk);
    chk("low_rsp1", {29'h0, p1_rsp_valid, p1_rsp_err, p0_rsp_valid}, 32'h6);
    chk("low_rdata1", p1_rsp_rdata, 0);
    tick();

    // RD_LAT=2 instance: three back-to-back reads
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drvb(1, 32'h8000_0000 + 32'(4*(c+1)), 4'h0, 0); else drvb(0, 0, 0, 0);
      @(negedge clk);
      chk("lat2_v", {31'h0, b_p0_rsp_valid}, (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
      chk("lat2_d", b_p0_rsp_rdata, (c >= 2 && c <= 4) ? 32'hB0B0_0000 + 32'(c-1) : 32'h0);
      tick();
    end
    chk("b_p1_idle", {b_p1_rsp_rdata[28:0], b_p1_req_ready, b_p1_rsp_valid, b_p1_rsp_err}, 0);
    chk("b_err", {31'h0, b_p0_rsp_err}, 0);

    // Reset with a read in flight (rr_ptr left at 1)
    drv0(1, 32'h8000_0010, 4'h0, 0);
    @(negedge clk);
    chk("mid_en", {31'h0, ram_en}, 1);
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_drop", {31'h0, p0_rsp_valid}, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {30'h0, p0_rsp_valid, p1_rsp_valid}, 0);
      tick();
    end
    drv0(1, 32'h8000_0020, 4'h0, 0);
    drv1(1, 32'h8000_0024, 4'h0, 0);
    @(negedge clk);
    chk("post_rst_rr", {30'h0, p1_req_ready, p0_req_ready}, 32'h1);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
